mips_mc_ctrl: RTL and testbench

//  Multi-cycle control FSM sequencing the PC logic, instruction register, register file, ALU and data memory.

---
 rtl/mips_mc_ctrl_if.sv | 30 +++
 rtl/mips_mc_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller (master) and the datapath/memory (slave).
interface mips_mc_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       pcsel;
    logic       jump;
    logic       ir_write;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, pcsel, jump, ir_write, mem_rd, mem_wr, iord,
               reg_write, reg_dst, mem_to_reg, alu_src, alu_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, pcsel, jump, ir_write, mem_rd, mem_wr, iord,
               reg_write, reg_dst, mem_to_reg, alu_src, alu_op
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory wait timeout (sticky bus_err) and retired-instruction counter.
// Optional CTRL_TRAP_EN: unknown opcodes trap to vector 0 and raise trap_flag instead of acting as NOPs.
module mips_mc_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    mips_mc_ctrl_if.master   bus,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       state
`ifdef CTRL_TRAP_EN
    ,
    output logic             trap_flag
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic waiting, timeout, retire;
    logic pc_en, pcsel, jump, ir_write, mem_rd, mem_wr, iord;
    logic reg_write, reg_dst, mem_to_reg, alu_src;
    logic [1:0] alu_op;
`ifdef CTRL_TRAP_EN
    logic trap_c;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            wait_cnt_q  <= '0;
            bus_err_q   <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_err_q   <= bus_err_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        pc_en      = 1'b0;
        pcsel      = 1'b0;
        jump       = 1'b0;
        ir_write   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
`ifdef CTRL_TRAP_EN
        trap_c     = 1'b0;
`endif

        // The wait timer only runs while an access is outstanding; a ready on the last allowed cycle still wins.
        waiting    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout    = waiting && !bus.mem_ready && (wait_cnt_q == WAIT_LAST);
        wait_cnt_d = (waiting && !bus.mem_ready && !timeout) ? wait_cnt_q + 8'd1 : 8'd0;
        bus_err_d  = bus_err_q | timeout;

        case (state_q)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (timeout) begin
                    state_d = S_HALT;
                end else if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE, OP_ADDI: state_d = S_EXEC;
                    OP_LW, OP_SW:      state_d = S_MEMADR;
                    OP_BEQ:            state_d = S_BRANCH;
                    OP_J:              state_d = S_JUMP;
                    default: begin
`ifdef CTRL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_FETCH;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src = 1'b1;
                state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (timeout)             state_d = S_HALT;
                else if (bus.mem_ready)  state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (timeout) begin
                    state_d = S_HALT;
                end else if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (bus.opcode == OP_ADDI) alu_src = 1'b1;
                else                       alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = (bus.opcode == OP_RTYPE);
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_op  = 2'b01;
                pcsel   = bus.zero;
                pc_en   = bus.zero;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                jump    = 1'b1;
                pc_en   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            S_TRAP: begin
`ifdef CTRL_TRAP_EN
                jump   = 1'b1;
                pc_en  = 1'b1;
                trap_c = 1'b1;
`endif
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Strobes are held off while reset is asserted so an aborted access never writes.
        if (reset) begin
            pc_en      = 1'b0;
            pcsel      = 1'b0;
            jump       = 1'b0;
            ir_write   = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            iord       = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src    = 1'b0;
            alu_op     = 2'b00;
`ifdef CTRL_TRAP_EN
            trap_c     = 1'b0;
`endif
        end

        instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, retire};
    end

    assign bus.pc_en      = pc_en;
    assign bus.pcsel      = pcsel;
    assign bus.jump       = jump;
    assign bus.ir_write   = ir_write;
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_wr     = mem_wr;
    assign bus.iord       = iord;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src    = alu_src;
    assign bus.alu_op     = alu_op;

    assign bus_err   = bus_err_q;
    assign instr_cnt = instr_cnt_q;
    assign state     = state_q;
`ifdef CTRL_TRAP_EN
    assign trap_flag = trap_c;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-cycle expected state/controls/count queued, then compared cycle by cycle.
module tb_mips_mc_ctrl;
    localparam int WAIT_MAX = 15;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC   = 4'd6;
    localparam logic [3:0] ST_ALUWB  = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_JUMP   = 4'd9;
    localparam logic [3:0] ST_HALT   = 4'd10;
    localparam logic [3:0] ST_TRAP   = 4'd11;

    localparam logic [12:0] C_PC_EN = 13'h1000;
    localparam logic [12:0] C_PCSEL = 13'h0800;
    localparam logic [12:0] C_JUMP  = 13'h0400;
    localparam logic [12:0] C_IRW   = 13'h0200;
    localparam logic [12:0] C_MRD   = 13'h0100;
    localparam logic [12:0] C_MWR   = 13'h0080;
    localparam logic [12:0] C_IORD  = 13'h0040;
    localparam logic [12:0] C_RW    = 13'h0020;
    localparam logic [12:0] C_RDST  = 13'h0010;
    localparam logic [12:0] C_M2R   = 13'h0008;
    localparam logic [12:0] C_ASRC  = 13'h0004;
    localparam logic [12:0] C_AFN   = 13'h0002;
    localparam logic [12:0] C_ASUB  = 13'h0001;
    localparam logic [12:0] FETCH_OK = C_PC_EN | C_IRW | C_MRD;

    typedef struct {
        logic        mr;
        logic        z;
        logic [3:0]  st;
        logic [12:0] ctl;
        logic [31:0] cnt;
    } item_t;

    logic        clk;
    logic        reset;
    logic        bus_err;
    logic [31:0] instr_cnt;
    logic [3:0]  state;
`ifdef CTRL_TRAP_EN
    logic        trap_flag;
`endif
    logic [12:0] obs_ctl;

    int          total;
    int          bad;
    logic [31:0] exp_cnt;
    item_t       sb[$];
    item_t       it;
    int          step;

    mips_mc_ctrl_if bus ();

    mips_mc_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .bus_err   (bus_err),
        .instr_cnt (instr_cnt),
        .state     (state)
`ifdef CTRL_TRAP_EN
        ,
        .trap_flag (trap_flag)
`endif
    );

    assign obs_ctl = {bus.pc_en, bus.pcsel, bus.jump, bus.ir_write, bus.mem_rd, bus.mem_wr, bus.iord,
                      bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src, bus.alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic mr, input logic z, input logic [3:0] st, input logic [12:0] ctl);
        item_t e;
        e.mr  = mr;
        e.z   = z;
        e.st  = st;
        e.ctl = ctl;
        e.cnt = exp_cnt;
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b0;
        bus.opcode = 6'b000000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (state !== ST_FETCH) begin bad++; $display("FAIL reset_state: got %0d want %0d", state, ST_FETCH); end
        total++;
        if (obs_ctl !== 13'h0) begin bad++; $display("FAIL reset_ctl: got %h want 0000", obs_ctl); end
        total++;
        if (bus_err !== 1'b0) begin bad++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        total++;
        if (instr_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", instr_cnt); end
        reset = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_alu();
        bus.opcode = 6'b000000;
        push(1, 0, ST_FETCH, FETCH_OK);
        push(1, 0, ST_DECODE, 13'h0);
        push(1, 0, ST_EXEC, C_AFN);
        push(1, 0, ST_ALUWB, C_RW | C_RDST);
        exp_cnt++;
        step = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.mem_ready = it.mr; bus.zero = it.z;
            #1;
            total++;
            if (state !== it.st || obs_ctl !== it.ctl || instr_cnt !== it.cnt) begin
                bad++;
                $display("FAIL rtype step%0d: got st=%0d ctl=%h cnt=%0d want st=%0d ctl=%h cnt=%0d",
                         step, state, obs_ctl, instr_cnt, it.st, it.ctl, it.cnt);
            end
            step++;
            @(negedge clk);
        end
        bus.opcode = 6'b001000;
        push(1, 0, ST_FETCH, FETCH_OK);
        push(1, 0, ST_DECODE, 13'h0);
        push(1, 0, ST_EXEC, C_ASRC);
        push(1, 0, ST_ALUWB, C_RW);
        exp_cnt++;
        step = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.mem_ready = it.mr; bus.zero = it.z;
            #1;
            total++;
            if (state !== it.st || obs_ctl !== it.ctl || instr_cnt !== it.cnt) begin
                bad++;
                $display("FAIL addi step%0d: got st=%0d ctl=%h cnt=%0d want st=%0d ctl=%h cnt=%0d",
                         step, state, obs_ctl, instr_cnt, it.st, it.ctl, it.cnt);
            end
            step++;
            @(negedge clk);
        end
        total++;
        if (instr_cnt !== exp_cnt) begin bad++; $display("FAIL alu_cnt: got %0d want %0d", instr_cnt, exp_cnt); end
    endtask

    task automatic test_mem();
        bus.opcode = 6'b100011;
        push(1, 0, ST_FETCH, FETCH_OK);
        push(1, 0, ST_DECODE, 13'h0);
        push(1, 0, ST_MEMADR, C_ASRC);
        for (int i = 0; i < 3; i++) push(0, 0, ST_MEMRD, C_MRD | C_IORD);
        push(1, 0, ST_MEMRD, C_MRD | C_IORD);
        push(1, 0, ST_MEMWB, C_RW | C_M2R);
        exp_cnt++;
        step = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.mem_ready = it.mr; bus.zero = it.z;
            #1;
            total++;
            if (state !== it.st || obs_ctl !== it.ctl || instr_cnt !== it.cnt) begin
                bad++;
                $display("FAIL lw step%0d: got st=%0d ctl=%h cnt=%0d want st=%0d ctl=%h cnt=%0d",
                         step, state, obs_ctl, instr_cnt, it.st, it.ctl, it.cnt);
            end
            step++;
            @(negedge clk);
        end
        bus.opcode = 6'b101011;
        push(1, 0, ST_FETCH, FETCH_OK);
        push(1, 0, ST_DECODE, 13'h0);
        push(1, 0, ST_MEMADR, C_ASRC);
        push(0, 0, ST_MEMWR, C_MWR | C_IORD);
        push(1, 0, ST_MEMWR, C_MWR | C_IORD);
        exp_cnt++;
        push(1, 0, ST_FETCH, FETCH_OK);
        step = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.mem_ready = it.mr; bus.zero = it.z;
            #1;
            total++;
            if (state !== it.st || obs_ctl !== it.ctl || instr_cnt !== it.cnt) begin
                bad++;
                $display("FAIL sw step%0d: got st=%0d ctl=%h cnt=%0d want st=%0d ctl=%h cnt=%0d",
                         step, state, obs_ctl, instr_cnt, it.st, it.ctl, it.cnt);
            end
            step++;
            @(negedge clk);
        end
        // the trailing FETCH consumed an instruction fetch; finish it as an R-type so the stream stays aligned
        bus.opcode = 6'b000000;
        push(1, 0, ST_DECODE, 13'h0);
        push(1, 0, ST_EXEC, C_AFN);
        push(1, 0, ST_ALUWB, C_RW | C_RDST);
        exp_cnt++;
        step = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.mem_ready = it.mr; bus.zero = it.z;
            #1;
            total++;
            if (state !== it.st || obs_ctl !== it.ctl || instr_cnt !== it.cnt) begin
                bad++;
                $display("FAIL b2b step%0d: got st=%0d ctl=%h cnt=%0d want st=%0d ctl=%h cnt=%0d",
                         step, state, obs_ctl, instr_cnt, it.st, it.ctl, it.cnt);
            end
            step++;
            @(negedge clk);
        end
    endtask

    task automatic test_branch_jump();
        bus.opcode = 6'b000100;
        push(1, 0, ST_FETCH, FETCH_OK);
        push(1, 0, ST_DECODE, 13'h0);
        push(1, 1, ST_BRANCH, C_PC_EN | C_PCSEL | C_ASUB);
        exp_cnt++;
        push(1, 0, ST_FETCH, FETCH_OK);
        push(1, 0, ST_DECODE, 13'h0);
        push(1, 0, ST_BRANCH, C_ASUB);
        exp_cnt++;
        step = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.mem_ready = it.mr; bus.zero = it.z;
            #1;
            total++;
            if (state !== it.st || obs_ctl !== it.ctl || instr_cnt !== it.cnt) begin
                bad++;
                $display("FAIL beq step%0d: got st=%0d ctl=%h cnt=%0d want st=%0d ctl=%h cnt=%0d",
                         step, state, obs_ctl, instr_cnt, it.st, it.ctl, it.cnt);
            end
            step++;
            @(negedge clk);
        end
        bus.zero = 1'b0;
        bus.opcode = 6'b000010;
        push(1, 0, ST_FETCH, FETCH_OK);
        push(1, 0, ST_DECODE, 13'h0);
        push(1, 0, ST_JUMP, C_JUMP | C_PC_EN);
        exp_cnt++;
        step = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.mem_ready = it.mr; bus.zero = it.z;
            #1;
            total++;
            if (state !== it.st || obs_ctl !== it.ctl || instr_cnt !== it.cnt) begin
                bad++;
                $display("FAIL jump step%0d: got st=%0d ctl=%h cnt=%0d want st=%0d ctl=%h cnt=%0d",
                         step, state, obs_ctl, instr_cnt, it.st, it.ctl, it.cnt);
            end
            step++;
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        #1;
        total++;
        if (state !== ST_FETCH || obs_ctl !== C_MRD || instr_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL jump_after: got st=%0d ctl=%h cnt=%0d want st=0 ctl=%h cnt=%0d",
                     state, obs_ctl, instr_cnt, C_MRD, exp_cnt);
        end
    endtask

    task automatic test_unknown();
        bus.opcode = 6'b111111;
        push(1, 0, ST_FETCH, FETCH_OK);
        push(1, 0, ST_DECODE, 13'h0);
        step = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.mem_ready = it.mr; bus.zero = it.z;
            #1;
            total++;
            if (state !== it.st || obs_ctl !== it.ctl || instr_cnt !== it.cnt) begin
                bad++;
                $display("FAIL unknown step%0d: got st=%0d ctl=%h cnt=%0d want st=%0d ctl=%h cnt=%0d",
                         step, state, obs_ctl, instr_cnt, it.st, it.ctl, it.cnt);
            end
            step++;
            @(negedge clk);
        end
`ifdef CTRL_TRAP_EN
        #1;
        total++;
        if (state !== ST_TRAP || obs_ctl !== (C_JUMP | C_PC_EN) || trap_flag !== 1'b1) begin
            bad++;
            $display("FAIL trap: got st=%0d ctl=%h tf=%b want st=%0d ctl=%h tf=1",
                     state, obs_ctl, trap_flag, ST_TRAP, C_JUMP | C_PC_EN);
        end
        @(negedge clk);
        total++;
        if (state !== ST_FETCH || trap_flag !== 1'b0 || instr_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL trap_exit: got st=%0d tf=%b cnt=%0d want st=0 tf=0 cnt=%0d",
                     state, trap_flag, instr_cnt, exp_cnt);
        end
`else
        exp_cnt++;
        total++;
        if (state !== ST_FETCH || instr_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL nop: got st=%0d cnt=%0d want st=0 cnt=%0d", state, instr_cnt, exp_cnt);
        end
`endif
    endtask

    task automatic test_wait_boundary();
        bus.opcode = 6'b000010;
        for (int i = 0; i < WAIT_MAX - 1; i++) push(0, 0, ST_FETCH, C_MRD);
        push(1, 0, ST_FETCH, FETCH_OK);
        push(1, 0, ST_DECODE, 13'h0);
        push(1, 0, ST_JUMP, C_JUMP | C_PC_EN);
        exp_cnt++;
        step = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.mem_ready = it.mr; bus.zero = it.z;
            #1;
            total++;
            if (state !== it.st || obs_ctl !== it.ctl || instr_cnt !== it.cnt) begin
                bad++;
                $display("FAIL wait_edge step%0d: got st=%0d ctl=%h cnt=%0d want st=%0d ctl=%h cnt=%0d",
                         step, state, obs_ctl, instr_cnt, it.st, it.ctl, it.cnt);
            end
            step++;
            @(negedge clk);
        end
        total++;
        if (bus_err !== 1'b0) begin bad++; $display("FAIL wait_edge_err: got %b want 0", bus_err); end
    endtask

    task automatic test_timeout();
        bus.opcode = 6'b000000;
        for (int i = 0; i < WAIT_MAX; i++) push(0, 0, ST_FETCH, C_MRD);
        push(1, 0, ST_HALT, 13'h0);
        push(1, 0, ST_HALT, 13'h0);
        push(1, 0, ST_HALT, 13'h0);
        step = 0;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.mem_ready = it.mr; bus.zero = it.z;
            #1;
            total++;
            if (state !== it.st || obs_ctl !== it.ctl || instr_cnt !== it.cnt) begin
                bad++;
                $display("FAIL timeout step%0d: got st=%0d ctl=%h cnt=%0d want st=%0d ctl=%h cnt=%0d",
                         step, state, obs_ctl, instr_cnt, it.st, it.ctl, it.cnt);
            end
            step++;
            @(negedge clk);
        end
        total++;
        if (bus_err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", bus_err); end
        reset = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (state !== ST_FETCH || obs_ctl !== 13'h0 || bus_err !== 1'b0 || instr_cnt !== 32'd0) begin
            bad++;
            $display("FAIL halt_reset: got st=%0d ctl=%h err=%b cnt=%0d want st=0 ctl=0000 err=0 cnt=0",
                     state, obs_ctl, bus_err, instr_cnt);
        end
        reset = 1'b0;
        exp_cnt = 32'd0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_cnt = 32'd0;
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_unknown();
        test_wait_boundary();
        test_timeout();
        test_alu();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

endmodule
